neander_x_ctrl: RTL and testbench
=================================

# neander_x_ctrl

Multi-cycle fetch/decode/execute sequencer for the NEANDER-X CPU. It owns the PC, IR, address register and accumulator. It drives the combinational ALU's operand and opcode inputs and consumes its result. It fetches instructions and operands over a single valid/ready memory port. Together with the ALU and memory it forms the complete core.

## Interface
- RESET_PC, default 8'h00: PC value loaded on reset.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  8  transaction address.
- mem_wdata  out  8  write data (always AC).
- mem_rdata  in  8  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  transaction completes on a cycle with mem_req & mem_ready.
- alu_a  out  8  always AC.
- alu_b  out  8  always mem_rdata.
- alu_op  out  2  00 ADD, 01 AND, 10 OR, 11 NOT, decoded from IR[7:4].
- alu_result  in  8  combinational ALU output.
- ac  out  8  accumulator.
- pc  out  8  program counter.
- flag_n  out  1  AC[7].
- flag_z  out  1  AC == 0.
- halted  out  1  1 in HALT state.
- illegal  out  1  sticky illegal-opcode indicator; constant 0 without the macro.

## Operation
- Opcode is IR[7:4]; IR[3:0] is ignored. NOP 0, STA 1, LDA 2, ADD 3, OR 4, AND 5, NOT 6, JMP 8, JN 9, JZ A, HLT F. Undefined: 7, B–E.
- alu_op mapping: ADD→00, AND→01, OR→10, NOT→11, all others→00.
- Reset values:
  - pc=RESET_PC; ac=0, IR=0, MAR=0, state=BOOT.
  - Outputs: mem_req=0, halted=0, illegal=0, flag_z=1, flag_n=0.
- BOOT: mem_req=0. Go to FETCH next cycle.
- FETCH: req=1, we=0, addr=PC. On ready: IR←rdata, PC←PC+1, go to DECODE.
- DECODE (no memory access):
  - NOP → FETCH.
  - NOT: AC←alu_result → FETCH.
  - HLT → HALT.
  - JN with N=0, or JZ with Z=0: PC←PC+1 (skip operand byte) → FETCH.
  - Opcodes 1–5, JMP, and taken JN/JZ → ADDR.
  - Undefined opcode: see Configuration.
- ADDR: req=1, we=0, addr=PC.
  - On ready, jumps: PC←rdata → FETCH.
  - On ready, otherwise: MAR←rdata, PC←PC+1, then STA → WRITE, others → READ.
- READ: req=1, we=0, addr=MAR. On ready: LDA loads AC←rdata; ADD/OR/AND load AC←alu_result. Then → FETCH.
- WRITE: req=1, we=1, addr=MAR, wdata=AC. On ready → FETCH.
- HALT: req=0, halted=1. Exit only via reset.
- Arithmetic and flags:
  - ADD is modulo 256, with no carry kept.
  - PC increments wrap FF→00, including during an operand-byte skip.
  - Flags are combinational from AC; jumps test the current AC.

## Timing
- Cycle counts with mem_ready held 1:
  - NOP, NOT, not-taken Jcc: 2 cycles.
  - JMP, taken Jcc: 3 cycles.
  - LDA, STA, ADD, OR, AND: 4 cycles.
- Each wait cycle (req=1, ready=0) adds one cycle. During a wait, mem_addr, mem_we, mem_wdata and state hold stable.
- mem_ready is ignored while mem_req=0.
- mem_req is a Moore output of the state; it never asserts in BOOT, DECODE or HALT.
- AC, PC and IR update on the clock edge that completes the transaction. New values are visible the following cycle.
- Reset asserted mid-transaction:
  - Immediately and asynchronously: state returns to BOOT, mem_req drops to 0 and all registers return to reset values.
  - The in-flight write is abandoned; memory must tolerate this.

## Configuration
- NEANDER_X_ILLEGAL_TRAP_EN defined: an undefined opcode in DECODE sets illegal=1 (sticky until reset) and goes to HALT.
- NEANDER_X_ILLEGAL_TRAP_EN undefined: an undefined opcode executes as a 2-cycle NOP and illegal stays 0.

## Test plan
- Reset/boot, mem_ready=1, mem[0]=0x20, mem[1]=0x80, mem[0x80]=0x05:
  - During reset, mem_req=0.
  - In the first cycle after release, mem_req=0 (BOOT).
  - After 4 more cycles, ac=0x05, pc=0x02, flag_z=0.
- Program LDA 80 / ADD 81 / STA 82 / HLT, with mem[80]=0x05 and mem[81]=0xFC:
  - Write of 0x01 to 0x82.
  - halted=1 and pc=0x07.
  - Exactly 4+4+4+2 cycles after BOOT.
- NOT and branches:
  - AC=0x00, NOT gives AC=0xFF and flag_n=1.
  - Then JZ 0x40 is not taken: pc advances by 2 in 2 cycles.
  - Then JN 0x40 is taken: pc=0x40 in 3 cycles.
- Wait states: mem_ready low for 3 cycles on every transaction.
  - mem_addr/mem_we/mem_wdata are stable throughout each wait.
  - LDA takes 4+3·3=13 cycles and gives the same result.
- Wrap and reset:
  - RESET_PC=0xFF with a NOP at 0xFF gives pc=0x00.
  - rst_n asserted during WRITE wait: mem_req falls the same cycle and pc returns to 0xFF.
- Illegal opcode 0x70:
  - With the macro: illegal=1 and halted=1.
  - Without it: pc advances by 1 in 2 cycles and illegal=0.

Source files
------------

// File: rtl/neander_x_ctrl.sv
// NEANDER-X fetch/decode/execute sequencer: owns PC, IR, AC and the memory-port FSM.
// Optional build macro NEANDER_X_ILLEGAL_TRAP_EN: undefined opcodes set a sticky illegal flag and halt.
`timescale 1ns/1ps
module neander_x_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       mem_req,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [1:0] alu_op,
    input  logic [7:0] alu_result,
    output logic [7:0] ac,
    output logic [7:0] pc,
    output logic       flag_n,
    output logic       flag_z,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ADDR   = 3'd3,
        S_READ   = 3'd4,
        S_WRITE  = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t     r_state;
    logic [7:0] r_pc;
    logic [7:0] r_ac;
    logic [3:0] r_ir;        // only the opcode nibble of IR is ever consulted
    logic       r_mem_req;
    logic       r_mem_we;
    logic [7:0] r_mem_addr;  // also serves as MAR while in READ/WRITE
    logic       r_halted;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
    logic       r_illegal;
`endif

    logic [7:0] w_pc_inc;
    logic       w_is_mem_op;
    logic       w_is_jump;
    logic       w_jcc_taken;
    logic       w_jcc_skip;
    logic       w_needs_addr;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
    logic       w_undef;
`endif

    assign w_pc_inc     = r_pc + 8'd1;
    assign w_is_mem_op  = (r_ir >= 4'h1) && (r_ir <= 4'h5);
    assign w_is_jump    = (r_ir == 4'h8) || (r_ir == 4'h9) || (r_ir == 4'hA);
    assign w_jcc_taken  = ((r_ir == 4'h9) && r_ac[7]) || ((r_ir == 4'hA) && (r_ac == 8'h00));
    assign w_jcc_skip   = ((r_ir == 4'h9) && !r_ac[7]) || ((r_ir == 4'hA) && (r_ac != 8'h00));
    assign w_needs_addr = w_is_mem_op || (r_ir == 4'h8) || w_jcc_taken;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
    assign w_undef      = (r_ir == 4'h7) || ((r_ir >= 4'hB) && (r_ir <= 4'hE));
`endif

    // ALU opcode decode from the instruction register
    always_comb begin
        alu_op = 2'b00;
        case (r_ir)
            4'h3:    alu_op = 2'b00;
            4'h5:    alu_op = 2'b01;
            4'h4:    alu_op = 2'b10;
            4'h6:    alu_op = 2'b11;
            default: alu_op = 2'b00;
        endcase
    end

    // Sequencer FSM; memory-port outputs are registered alongside the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_ac       <= 8'h00;
            r_ir       <= 4'h0;
            r_mem_req  <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= 8'h00;
            r_halted   <= 1'b0;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
            r_illegal  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state    <= S_FETCH;
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_pc;
                end
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir      <= mem_rdata[7:4];
                        r_pc      <= w_pc_inc;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (r_ir == 4'hF) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_needs_addr) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                        r_state    <= S_ADDR;
                    end else if (w_jcc_skip) begin
                        // not-taken branch steps over its operand byte
                        r_pc       <= w_pc_inc;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= w_pc_inc;
                        r_state    <= S_FETCH;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
                    end else if (w_undef) begin
                        r_illegal <= 1'b1;
                        r_halted  <= 1'b1;
                        r_state   <= S_HALT;
`endif
                    end else begin
                        if (r_ir == 4'h6) begin
                            r_ac <= alu_result;
                        end else begin
                            r_ac <= r_ac;
                        end
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                S_ADDR: begin
                    if (mem_ready) begin
                        if (w_is_jump) begin
                            r_pc       <= mem_rdata;
                            r_mem_addr <= mem_rdata;
                            r_mem_we   <= 1'b0;
                            r_state    <= S_FETCH;
                        end else begin
                            r_pc       <= w_pc_inc;
                            r_mem_addr <= mem_rdata;
                            r_mem_we   <= (r_ir == 4'h1);
                            r_state    <= (r_ir == 4'h1) ? S_WRITE : S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ready) begin
                        r_ac       <= (r_ir == 4'h2) ? mem_rdata : alu_result;
                        r_mem_addr <= r_pc;
                        r_mem_we   <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        r_mem_addr <= r_pc;
                        r_mem_we   <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    r_mem_req <= 1'b0;
                    r_state   <= S_HALT;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_state   <= S_BOOT;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_ac;
    assign alu_a     = r_ac;
    assign alu_b     = mem_rdata;
    assign ac        = r_ac;
    assign pc        = r_pc;
    assign flag_n    = r_ac[7];
    assign flag_z    = (r_ac == 8'h00);
    assign halted    = r_halted;
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
    assign illegal   = r_illegal;
`else
    assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_neander_x_ctrl.sv
// Scoreboard bench for neander_x_ctrl: an instruction-level ISA model predicts every memory
// transaction, the AC at each fetch, the final state and the cycle count.
`timescale 1ns/1ps
module tb_neander_x_ctrl;

    typedef struct packed {
        logic       fetch;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       mem_req, mem_we, mem_ready;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] alu_a, alu_b, alu_result, ac, pc;
    logic [1:0] alu_op;
    logic       flag_n, flag_z, halted, illegal;

    logic       rst2_n, req2, we2, ready2, fn2, fz2, h2, il2;
    logic [7:0] addr2, wdata2, rdata2, a2, b2, res2, ac2, pc2;
    logic [1:0] op2;

    logic [7:0] mem  [256];
    logic [7:0] mm   [256];
    logic [7:0] img  [256];
    logic [7:0] m2   [256];
    exp_t       sbq  [$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;
    int         wait_mode = 0;
    int         nwaits = 0;

    function automatic logic [7:0] alu_f(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a & b;
            2'b10:   return a | b;
            default: return ~a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);
    assign mem_rdata  = mem[mem_addr];
    assign res2       = alu_f(op2, a2, b2);
    assign rdata2     = m2[addr2];

    neander_x_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_a(alu_a),
        .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .ac(ac), .pc(pc),
        .flag_n(flag_n), .flag_z(flag_z), .halted(halted), .illegal(illegal)
    );

    neander_x_ctrl #(.RESET_PC(8'hFF)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
        .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(ready2), .alu_a(a2),
        .alu_b(b2), .alu_op(op2), .alu_result(res2), .ac(ac2), .pc(pc2),
        .flag_n(fn2), .flag_z(fz2), .halted(h2), .illegal(il2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic f, input logic w, input logic [7:0] ad, input logic [7:0] d);
        exp_t e;
        e.fetch = f;
        e.we    = w;
        e.addr  = ad;
        e.data  = d;
        return e;
    endfunction

    // ISA-level reference: walks the program in mm[], queueing each expected transaction
    task automatic run_model(input int cap, output logic [7:0] eac, output logic [7:0] epc,
                             output bit ehalt, output bit eill, output int base, output int ntr);
        logic [7:0] p, a, v, opnd;
        logic [3:0] op;
        bit         taken;
        p = 8'h00; a = 8'h00; ehalt = 1'b0; eill = 1'b0; base = 1; ntr = 0;
        for (int n = 0; n < cap && !ehalt; n++) begin
            sbq.push_back(mk(1'b1, 1'b0, p, a));
            ntr++;
            op = mm[p][7:4];
            p  = p + 8'd1;
            case (op)
                4'h0: base += 2;
                4'h6: begin a = ~a; base += 2; end
                4'hF: begin ehalt = 1'b1; base += 2; end
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                    opnd = mm[p];
                    sbq.push_back(mk(1'b0, 1'b0, p, 8'h00));
                    p = p + 8'd1;
                    if (op == 4'h1) begin
                        sbq.push_back(mk(1'b0, 1'b1, opnd, a));
                        mm[opnd] = a;
                    end else begin
                        sbq.push_back(mk(1'b0, 1'b0, opnd, 8'h00));
                        v = mm[opnd];
                        case (op)
                            4'h2:    a = v;
                            4'h3:    a = a + v;
                            4'h4:    a = a | v;
                            default: a = a & v;
                        endcase
                    end
                    ntr += 2;
                    base += 4;
                end
                4'h8, 4'h9, 4'hA: begin
                    taken = (op == 4'h8) || (op == 4'h9 && a[7]) || (op == 4'hA && a == 8'h00);
                    if (taken) begin
                        sbq.push_back(mk(1'b0, 1'b0, p, 8'h00));
                        ntr++;
                        p = mm[p];
                        base += 3;
                    end else begin
                        p = p + 8'd1;
                        base += 2;
                    end
                end
                default: begin
`ifdef NEANDER_X_ILLEGAL_TRAP_EN
                    ehalt = 1'b1;
                    eill  = 1'b1;
`endif
                    base += 2;
                end
            endcase
        end
        eac = a;
        epc = p;
    endtask

    // Memory responder: applies wait states and performs writes that will complete
    initial begin
        bit fire;
        bit in_txn;
        int wleft;
        mem_ready = 1'b0; fire = 1'b0; in_txn = 1'b0; wleft = 0;
        forever begin
            @(negedge clk);
            fire = rst_n && mem_req && mem_ready;
            if (fire && mem_we) mem[mem_addr] = mem_wdata;
            @(posedge clk);
            #2;
            if (fire || !mem_req) in_txn = 1'b0;
            if (mem_req && !in_txn) begin
                in_txn = 1'b1;
                wleft  = (wait_mode == 1) ? 3 : (wait_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            end
            if (mem_req && wleft > 0) begin
                mem_ready = 1'b0;
                wleft--;
                nwaits++;
            end else if (mem_req) begin
                mem_ready = 1'b1;
            end else begin
                mem_ready = (wait_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b1;
            end
        end
    end

    // Monitor: every requesting cycle is compared with the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && mem_req && sbq.size() > 0) begin
            mon_e = sbq[0];
            chk("txn_addr", mem_addr, mon_e.addr);
            chk("txn_we", mem_we, mon_e.we);
            if (mon_e.we) chk("txn_wdata", mem_wdata, mon_e.data);
            if (mem_ready) begin
                if (mon_e.fetch) begin
                    chk("fetch_ac", ac, mon_e.data);
                    chk("fetch_pc", pc, mon_e.addr);
                    chk("fetch_z", flag_z, mon_e.data == 8'h00);
                    chk("fetch_n", flag_n, mon_e.data[7]);
                end
                void'(sbq.pop_front());
            end
        end
    end

    task automatic clear_img();
        for (int i = 0; i < 256; i++) img[i] = 8'h00;
    endtask

    task automatic rand_img();
        int k;
        for (int i = 0; i < 256; i++) begin
            k = int'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) img[i] = 8'($urandom_range(0, 255));
            else img[i] = {((k == 11) ? 4'hF : 4'(k)), 4'($urandom_range(0, 15))};
        end
    endtask

    task automatic run_prog(input string nm, input int cap, input int mode);
        logic [7:0] eac, epc;
        bit         eh, ei;
        int         base, ntr, cyc, expc;
        rst_n = 1'b0;
        #2;
        wait_mode = mode;
        sbq.delete();
        for (int i = 0; i < 256; i++) begin
            mem[i] = img[i];
            mm[i]  = img[i];
        end
        run_model(cap, eac, epc, eh, ei, base, ntr);
        chk({nm, "_rst_req"}, mem_req, 1'b0);
        chk({nm, "_rst_pc"}, pc, 8'h00);
        chk({nm, "_rst_ac"}, ac, 8'h00);
        chk({nm, "_rst_flags"}, {flag_z, flag_n, halted, illegal}, 4'b1000);
        @(negedge clk);
        rst_n  = 1'b1;
        nwaits = 0;
        #1;
        chk({nm, "_boot_req"}, mem_req, 1'b0);
        cyc = 0;
        while (cyc < 4000 && !(eh ? (halted === 1'b1) : (sbq.size() == 0))) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done"}, cyc < 4000, 1'b1);
        chk({nm, "_illegal"}, illegal, ei);
        if (eh) begin
            expc = base + ((mode == 1) ? 3 * ntr : (mode == 2) ? nwaits : 0);
            chk({nm, "_halted"}, halted, 1'b1);
            chk({nm, "_ac"}, ac, eac);
            chk({nm, "_pc"}, pc, epc);
            chk({nm, "_cycles"}, cyc, expc);
            chk({nm, "_sb_empty"}, sbq.size(), 0);
        end
    endtask

    // Reset-PC wrap and reset asserted in the middle of a stalled write
    task automatic reset_wrap_test();
        int n;
        for (int i = 0; i < 256; i++) m2[i] = 8'h00;
        m2[8'h00] = 8'h10;
        m2[8'h01] = 8'h30;
        ready2 = 1'b1;
        rst2_n = 1'b0;
        #1;
        chk("wrap_rst_pc", pc2, 8'hFF);
        chk("wrap_rst_out", {req2, h2, il2, fz2, fn2}, 5'b00010);
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("wrap_pc", pc2, 8'h00);
        n = 0;
        while (n < 20 && !(req2 && we2)) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_write_seen", n < 20, 1'b1);
        ready2 = 1'b0;
        chk("wrap_write_addr", addr2, 8'h30);
        chk("wrap_write_data", wdata2, ac2);
        @(negedge clk);
        chk("wrap_wait_req", {req2, we2, addr2}, {2'b11, 8'h30});
        #1;
        rst2_n = 1'b0;
        #1;
        chk("midwrite_req", req2, 1'b0);
        chk("midwrite_pc", pc2, 8'hFF);
        chk("midwrite_ac", ac2, 8'h00);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        ready2 = 1'b1;
        repeat (2) @(negedge clk);

        clear_img();
        img[8'h00] = 8'h20; img[8'h01] = 8'h80; img[8'h02] = 8'hF0; img[8'h80] = 8'h05;
        run_prog("boot_lda", 10, 0);

        clear_img();
        img[8'h00] = 8'h20; img[8'h01] = 8'h80; img[8'h02] = 8'h30; img[8'h03] = 8'h81;
        img[8'h04] = 8'h10; img[8'h05] = 8'h82; img[8'h06] = 8'hF0;
        img[8'h80] = 8'h05; img[8'h81] = 8'hFC;
        run_prog("prog", 10, 0);
        chk("prog_mem82", mem[8'h82], 8'h01);
        run_prog("prog_wait", 10, 1);
        chk("prog_wait_mem82", mem[8'h82], 8'h01);

        clear_img();
        img[8'h00] = 8'h60; img[8'h01] = 8'hA0; img[8'h02] = 8'h40;
        img[8'h03] = 8'h90; img[8'h04] = 8'h40; img[8'h40] = 8'hF0;
        run_prog("not_branch", 10, 0);

        clear_img();
        img[8'h00] = 8'h70; img[8'h01] = 8'hF0;
        run_prog("illegal", 10, 0);

        for (int t = 0; t < 30; t++) begin
            rand_img();
            run_prog("rand", 60, 2);
        end

        reset_wrap_test();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
